// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel switch conditioner: channel state encoding
// and counter sizing helpers.
package panel_pkg;

  typedef enum logic [1:0] {
    PS_IDLE         = 2'd0,
    PS_PRESS_WAIT   = 2'd1,
    PS_HELD         = 2'd2,
    PS_RELEASE_WAIT = 2'd3
  } panel_state_e;

  // Bits needed to hold values 0..max_count, never less than one.
  function automatic int unsigned count_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/panel_switch_conditioner_if.sv
// Button-side bundle of the switch conditioner: raw pins in, clean levels,
// sample tick and press/release pulses out.
interface panel_switch_conditioner_if #(
  parameter int NBUT = 4
);
  logic [NBUT-1:0] but_raw;
  logic            tick;
  logic [NBUT-1:0] level;
  logic [NBUT-1:0] press;
  logic [NBUT-1:0] release_pulse;

  modport master (output but_raw, input tick, level, press, release_pulse);
  modport slave  (input but_raw, output tick, level, press, release_pulse);
endinterface

// File: rtl/panel_debounce_chan.sv
// One button channel: 2-flop synchroniser, tick-driven debounce FSM, registered outputs.
// Optional auto-repeat of press pulses while held is built when PANEL_AUTOREPEAT_EN is defined.
module panel_debounce_chan
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 8,
  parameter int ACTIVE_LOW     = 1,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam logic RAW_RELEASED = (ACTIVE_LOW != 0);
`ifdef PANEL_AUTOREPEAT_EN
  localparam int CW = count_width(max2(DEBOUNCE_TICKS, REPEAT_DELAY));
  localparam int RW = count_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] RD_L = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RP_L = RW'(REPEAT_PERIOD);
`else
  localparam int CW = count_width(DEBOUNCE_TICKS);
`endif
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE_TICKS);

  logic         sync1_q, sync2_q, s;
  panel_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d, count_inc;
  logic         level_q, level_d;
  logic         press_q, press_d, accept_press;
  logic         release_q, release_d;

  // Synchronisers start at the released pin value so reset exit looks like "no press".
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RAW_RELEASED;
      sync2_q <= RAW_RELEASED;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign s         = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

`ifdef PANEL_AUTOREPEAT_EN
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  logic          rep_late_q, rep_late_d, rep_pulse;

  assign rep_inc = (rep_q == '1) ? rep_q : rep_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q      <= '0;
      rep_late_q <= 1'b0;
    end else begin
      rep_q      <= rep_d;
      rep_late_q <= rep_late_d;
    end
  end
`endif

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    level_d      = level_q;
    accept_press = 1'b0;
    release_d    = 1'b0;
`ifdef PANEL_AUTOREPEAT_EN
    rep_d        = rep_q;
    rep_late_d   = rep_late_q;
    rep_pulse    = 1'b0;
`endif
    if (tick) begin
      unique case (state_q)
        PS_IDLE: begin
          if (s) begin
            if (DEBOUNCE_TICKS <= 1) begin
              state_d      = PS_HELD;
              count_d      = '0;
              level_d      = 1'b1;
              accept_press = 1'b1;
            end else begin
              state_d = PS_PRESS_WAIT;
              count_d = CW'(1);
            end
          end
        end
        PS_PRESS_WAIT: begin
          if (!s) begin
            state_d = PS_IDLE;
            count_d = '0;
          end else if (count_inc >= DB) begin
            state_d      = PS_HELD;
            count_d      = '0;
            level_d      = 1'b1;
            accept_press = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end
        PS_HELD: begin
          if (!s) begin
            if (DEBOUNCE_TICKS <= 1) begin
              state_d   = PS_IDLE;
              count_d   = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              state_d = PS_RELEASE_WAIT;
              count_d = CW'(1);
            end
          end
`ifdef PANEL_AUTOREPEAT_EN
          else if (rep_inc >= (rep_late_q ? RP_L : RD_L)) begin
            rep_pulse  = 1'b1;
            rep_d      = '0;
            rep_late_d = 1'b1;
          end else begin
            rep_d = rep_inc;
          end
`endif
        end
        PS_RELEASE_WAIT: begin
          if (s) begin
            state_d = PS_HELD;
            count_d = '0;
          end else if (count_inc >= DB) begin
            state_d   = PS_IDLE;
            count_d   = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end
        default: begin
          state_d = PS_IDLE;
          count_d = '0;
          level_d = 1'b0;
        end
      endcase
    end
`ifdef PANEL_AUTOREPEAT_EN
    // A fresh acceptance restarts the repeat schedule; a bounce back into HELD does not.
    if (accept_press) begin
      rep_d      = '0;
      rep_late_d = 1'b0;
    end
    press_d = accept_press | rep_pulse;
`else
    press_d = accept_press;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PS_IDLE;
      count_q   <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/panel_switch_conditioner.sv
// Front-panel button conditioner: shared sample-tick prescaler feeding NBUT debounce channels.
// Define PANEL_AUTOREPEAT_EN to build auto-repeat press pulses for held buttons.
module panel_switch_conditioner
  import panel_pkg::*;
#(
  parameter int NBUT           = 4,
  parameter int CLK_HZ         = 12_500_000,
  parameter int TICK_HZ        = 1_000,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int ACTIVE_LOW     = 1,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input logic                        SYSCLK,
  input logic                        nRESET,
  panel_switch_conditioner_if.slave  sw
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = count_width(DIV - 1);

  logic [PW-1:0]   presc_q;
  logic            tick;
  logic [NBUT-1:0] level_v, press_v, release_v;

  assign tick = (presc_q == PW'(DIV - 1));

  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET)   presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 1'b1;
  end

  for (genvar g = 0; g < NBUT; g++) begin : g_chan
    panel_debounce_chan #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk           (SYSCLK),
      .rst_n         (nRESET),
      .tick          (tick),
      .raw           (sw.but_raw[g]),
      .level         (level_v[g]),
      .press         (press_v[g]),
      .release_pulse (release_v[g])
    );
  end

  assign sw.tick          = tick;
  assign sw.level         = level_v;
  assign sw.press         = press_v;
  assign sw.release_pulse = release_v;

endmodule
